// File: rtl/usbhid_report_uart.sv
// usbhid_report_uart
// Turns HID reports into ASCII-hex text lines on a UART TX pin.
// Each accepted report becomes one line: for every byte (index 0 first) the
// high nibble and then the low nibble as uppercase hex, followed by CR LF.
// Frames are 8N1 and each bit lasts C_div = C_clk_hz/C_baud clock cycles.
// The next character's start bit directly follows the previous stop bit.
// While a line is being sent, one newer report is held in a pending slot.
// If that slot is already full, the newer report replaces it and overrun pulses.
// Ports:
//   clk        in   clock (HID host domain)
//   resetn     in   asynchronous active-low reset
//   hid_report in   report, byte i = hid_report[8*i+7:8*i]
//   hid_valid  in   one-cycle strobe qualifying hid_report
//   txd        out  UART serial output, idle high
//   busy       out  a line is in progress or a report is pending
//   overrun    out  one-cycle pulse when the pending report was replaced
module usbhid_report_uart #(
    parameter int C_report_bytes = 20,
    parameter int C_clk_hz       = 6000000,
    parameter int C_baud         = 115200,
    parameter int C_only_changes = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [C_report_bytes*8-1:0] hid_report,
    input  logic                        hid_valid,
    output logic                        txd,
    output logic                        busy,
    output logic                        overrun
);

    localparam int RPT_W   = C_report_bytes * 8;
    localparam int C_div   = C_clk_hz / C_baud;
    localparam int C_chars = 2 * C_report_bytes + 2;
    localparam int CHR_W   = $clog2(C_chars);
    localparam int CNT_W   = $clog2(C_div);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_div - 1);
    localparam logic [CHR_W-1:0] CHR_LAST = CHR_W'(C_chars - 1);
    localparam logic [CHR_W-1:0] CHR_CR   = CHR_W'(C_chars - 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // Maps a nibble to its uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) begin
            ch = 8'h30 + {4'h0, nib};
        end else begin
            ch = 8'h37 + {4'h0, nib};
        end
        return ch;
    endfunction

    // Character idx of the text line for report rpt (hex digits, then CR, LF).
    function automatic logic [7:0] line_char(input logic [RPT_W-1:0] rpt,
                                             input logic [CHR_W-1:0] idx);
        logic [7:0] byt;
        logic [7:0] ch;
        byt = 8'h00;
        for (int i = 0; i < C_report_bytes; i++) begin
            if (int'(idx >> 1) == i) begin
                byt = rpt[8*i +: 8];
            end else begin
                byt = byt;
            end
        end
        if (idx == CHR_LAST) begin
            ch = 8'h0A;
        end else if (idx == CHR_CR) begin
            ch = 8'h0D;
        end else if (idx[0]) begin
            ch = hex_ascii(byt[3:0]);
        end else begin
            ch = hex_ascii(byt[7:4]);
        end
        return ch;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [CHR_W-1:0]   chr_q, chr_d;
    logic [7:0]         sh_q, sh_d;
    logic [RPT_W-1:0]   buf_q, buf_d;
    logic [RPT_W-1:0]   pend_q, pend_d;
    logic               pend_v_q, pend_v_d;
    logic [RPT_W-1:0]   last_q, last_d;
    logic               txd_q, txd_d;
    logic               busy_q, busy_d;
    logic               ovr_q, ovr_d;
    logic               accept_s;
    logic               tick_s;
    logic [CNT_W-1:0]   cnt_inc_s;

    // Report acceptance filter and baud tick.
    always_comb begin
        accept_s  = hid_valid && ((C_only_changes == 0) || (hid_report != last_q));
        tick_s    = (cnt_q == CNT_LAST);
        cnt_inc_s = cnt_q + CNT_W'(1);
    end

    // Next-state logic for the line FSM, pending slot and registered outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        chr_d    = chr_q;
        sh_d     = sh_q;
        buf_d    = buf_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        last_d   = last_q;
        txd_d    = txd_q;
        ovr_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (accept_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Freeze the line content; the pending slot is free again.
                buf_d    = pend_q;
                pend_v_d = 1'b0;
                chr_d    = '0;
                cnt_d    = '0;
                sh_d     = line_char(pend_q, '0);
                txd_d    = 1'b0;
                state_d  = ST_START;
            end
            ST_START: begin
                if (tick_s) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    txd_d   = sh_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = {1'b0, sh_q[7:1]};
                        txd_d = sh_q[1];
                    end
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    cnt_d = '0;
                    if (chr_q == CHR_LAST) begin
                        // A report arriving on this very edge is taken by LOAD.
                        if (pend_v_q || accept_s) begin
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        chr_d   = chr_q + CHR_W'(1);
                        sh_d    = line_char(buf_q, chr_q + CHR_W'(1));
                        txd_d   = 1'b0;
                        state_d = ST_START;
                    end
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        // Accepted reports always go through the pending slot. In LOAD the
        // old content is being consumed this cycle, so nothing is lost.
        if (accept_s) begin
            last_d   = hid_report;
            pend_d   = hid_report;
            pend_v_d = 1'b1;
            if (pend_v_q && (state_q != ST_LOAD)) begin
                ovr_d = 1'b1;
            end else begin
                ovr_d = 1'b0;
            end
        end else begin
            ovr_d = 1'b0;
        end
        busy_d = (state_d != ST_IDLE) || pend_v_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            chr_q    <= '0;
            sh_q     <= 8'h00;
            buf_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            last_q   <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            chr_q    <= chr_d;
            sh_q     <= sh_d;
            buf_q    <= buf_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            last_q   <= last_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
        end
    end

    assign txd     = txd_q;
    assign busy    = busy_q;
    assign overrun = ovr_q;

endmodule
